// File: rtl/serial_kl8e_param_pkg.sv
// Shared constants for the parametrised KL8E console serial block:
// CPU major-state encodings, IOT opcodes and the TX/RX FSM state types.
package serial_kl8e_param_pkg;

  localparam logic [3:0] F0 = 4'd0;
  localparam logic [3:0] F1 = 4'd1;
  localparam logic [3:0] F2 = 4'd2;
  localparam logic [3:0] F3 = 4'd3;

  localparam logic [2:0] IOT_MAJOR = 3'b110;

  // Keyboard operations (instruction[9:11])
  localparam logic [2:0] OP_KCF = 3'd0;
  localparam logic [2:0] OP_KSF = 3'd1;
  localparam logic [2:0] OP_KCC = 3'd2;
  localparam logic [2:0] OP_KRS = 3'd4;
  localparam logic [2:0] OP_KIE = 3'd5;
  localparam logic [2:0] OP_KRB = 3'd6;

  // Teleprinter operations
  localparam logic [2:0] OP_SPF = 3'd0;
  localparam logic [2:0] OP_TSF = 3'd1;
  localparam logic [2:0] OP_TCF = 3'd2;
  localparam logic [2:0] OP_TPC = 3'd4;
  localparam logic [2:0] OP_SPI = 3'd5;
  localparam logic [2:0] OP_TLS = 3'd6;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period down-counter: load_i arms a full bit, half_i arms half a bit;
// expire_o is high once the armed period has elapsed.
module serial_bit_timer #(
  parameter int BAUD_DIV = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic half_i,
  output logic expire_o
);

  localparam int CW = $clog2(BAUD_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(BAUD_DIV - 1);
    else if (half_i)
      cnt_d = CW'(BAUD_DIV / 2 - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/serial_kl8e_param.sv
// KL8E-compatible keyboard/teleprinter with parametrised timing and device codes.
// Define SERIAL_RX_FIFO_EN to queue received bytes in a FIFO_DEPTH-entry FIFO.
module serial_kl8e_param
  import serial_kl8e_param_pkg::*;
#(
  parameter int         BAUD_DIV   = 868,
  parameter int         DATA_BITS  = 8,
  parameter int         STOP_BITS  = 1,
  parameter logic [5:0] KBD_DEV    = 6'o03,
  parameter logic [5:0] TTY_DEV    = 6'o04,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] instruction,
  input  logic [3:0]  state,
  input  logic [0:11] ac,
  input  logic        rx,
  output logic [0:11] serial_bus,
  output logic        tx,
  output logic        interrupt,
  output logic        skip
);

  localparam logic [7:0] RX_MASK = (DATA_BITS == 7) ? 8'h7F : 8'hFF;

  logic [2:0] op;
  logic       iot_f3, kbd_sel, tty_sel;
  logic       kbd_clr, tty_set, tty_clr, tx_go, kie;
  logic       kbd_flag, tty_flag_q, tty_flag_d, ie_q, int_q;
  logic [7:0] rx_head, rx_byte;
  logic       rx_push, tx_done;
  logic       unused_ac;

  assign unused_ac = ^ac[0:3];

  assign op      = instruction[9:11];
  assign iot_f3  = (instruction[0:2] == IOT_MAJOR) && (state == F3);
  assign kbd_sel = iot_f3 && (instruction[3:8] == KBD_DEV);
  assign tty_sel = iot_f3 && (instruction[3:8] == TTY_DEV);

  assign kbd_clr = kbd_sel && (op == OP_KCF || op == OP_KCC || op == OP_KRB);
  assign kie     = kbd_sel && (op == OP_KIE);
  assign tty_set = tty_sel && (op == OP_SPF);
  assign tty_clr = tty_sel && (op == OP_TCF || op == OP_TLS);
  assign tx_go   = tty_sel && (op == OP_TPC || op == OP_TLS);

  always_comb begin
    skip       = 1'b0;
    serial_bus = '0;
    if (kbd_sel) begin
      case (op)
        OP_KSF:         skip = kbd_flag;
        OP_KRS, OP_KRB: serial_bus = {4'b0000, rx_head & RX_MASK};
        default: ;
      endcase
    end
    if (tty_sel) begin
      case (op)
        OP_TSF:  skip = tty_flag_q;
        OP_SPI:  skip = ie_q & (kbd_flag | tty_flag_q);
        default: ;
      endcase
    end
  end

  // ---------------- Transmitter ----------------
  tx_state_e  tx_st_q, tx_st_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic       tx_q, tx_d, tx_load, tx_exp;

  serial_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tx_load),
    .half_i   (1'b0),
    .expire_o (tx_exp)
  );

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_cnt_d = tx_cnt_q;
    tx_d     = tx_q;
    tx_load  = 1'b0;
    tx_done  = 1'b0;
    case (tx_st_q)
      TX_IDLE: if (tx_go) begin
        tx_sh_d = ac[4:11];
        tx_d    = 1'b0;
        tx_load = 1'b1;
        tx_st_d = TX_START;
      end
      TX_START: if (tx_exp) begin
        tx_d     = tx_sh_q[0];
        tx_sh_d  = tx_sh_q >> 1;
        tx_cnt_d = '0;
        tx_load  = 1'b1;
        tx_st_d  = TX_DATA;
      end
      TX_DATA: if (tx_exp) begin
        tx_load = 1'b1;
        if (tx_cnt_q == 3'(DATA_BITS - 1)) begin
          tx_d     = 1'b1;
          tx_cnt_d = '0;
          tx_st_d  = TX_STOP;
        end else begin
          tx_d     = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
          tx_cnt_d = tx_cnt_q + 3'd1;
        end
      end
      TX_STOP: if (tx_exp) begin
        if (tx_cnt_q == 3'(STOP_BITS - 1)) begin
          tx_done = 1'b1;
          tx_st_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 3'd1;
          tx_load  = 1'b1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st_q  <= TX_IDLE;
      tx_sh_q  <= '0;
      tx_cnt_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_sh_q  <= tx_sh_d;
      tx_cnt_q <= tx_cnt_d;
      tx_q     <= tx_d;
    end
  end

  assign tx = tx_q;

  // ---------------- Receiver ----------------
  rx_state_e  rx_st_q, rx_st_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  logic       rx_load, rx_half, rx_exp;

  serial_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (rx_load),
    .half_i   (rx_half),
    .expire_o (rx_exp)
  );

  // With 7 data bits the character ends up in the top seven shift bits.
  assign rx_byte = (DATA_BITS == 8) ? rx_sh_q : {1'b0, rx_sh_q[7:1]};

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_sh_d  = rx_sh_q;
    rx_cnt_d = rx_cnt_q;
    rx_load  = 1'b0;
    rx_half  = 1'b0;
    rx_push  = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_half = 1'b1;
        rx_st_d = RX_START;
      end
      RX_START: if (rx_exp) begin
        if (!rx_sync_q) begin
          rx_load  = 1'b1;
          rx_cnt_d = '0;
          rx_st_d  = RX_DATA;
        end else begin
          rx_st_d = RX_IDLE;
        end
      end
      RX_DATA: if (rx_exp) begin
        rx_load = 1'b1;
        rx_sh_d = {rx_sync_q, rx_sh_q[7:1]};
        if (rx_cnt_q == 3'(DATA_BITS - 1)) rx_st_d = RX_STOP;
        else                               rx_cnt_d = rx_cnt_q + 3'd1;
      end
      RX_STOP: if (rx_exp) begin
        if (rx_sync_q) begin
          rx_push = 1'b1;
          rx_st_d = RX_IDLE;
        end else begin
          rx_st_d = RX_WAIT;
        end
      end
      RX_WAIT: if (rx_sync_q) rx_st_d = RX_IDLE;
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st_q   <= RX_IDLE;
      rx_sh_q   <= '0;
      rx_cnt_q  <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_sh_q   <= rx_sh_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------- Receive buffer ----------------
`ifdef SERIAL_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic        do_push, do_pop;

  assign do_push  = rx_push && (count_q != (AW+1)'(FIFO_DEPTH));
  assign do_pop   = kbd_clr && (count_q != '0);
  assign rx_head  = fifo_mem[rd_ptr_q];
  assign kbd_flag = (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [7:0] rxbuf_q;
  logic       kbd_flag_q;

  assign rx_head  = rxbuf_q;
  assign kbd_flag = kbd_flag_q;

  // An arriving byte beats a same-cycle clear so the new character is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxbuf_q    <= '0;
      kbd_flag_q <= 1'b0;
    end else begin
      if (rx_push) begin
        rxbuf_q    <= rx_byte;
        kbd_flag_q <= 1'b1;
      end else if (kbd_clr) begin
        kbd_flag_q <= 1'b0;
      end
    end
  end
`endif

  // ---------------- Flags and interrupt ----------------
  always_comb begin
    tty_flag_d = tty_flag_q;
    if (tx_done) tty_flag_d = 1'b1;
    if (tty_clr) tty_flag_d = 1'b0;
    if (tty_set) tty_flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tty_flag_q <= 1'b0;
      ie_q       <= 1'b1;
      int_q      <= 1'b0;
    end else begin
      tty_flag_q <= tty_flag_d;
      if (kie) ie_q <= ac[11];
      int_q <= ie_q & (kbd_flag | tty_flag_q);
    end
  end

  assign interrupt = int_q;

endmodule
